// File: rtl/lcd_pkg.sv
// Shared state encoding, default timing and the power-on command table
// for the LCD bus arbiter.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT_CMD = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    PULSE    = 3'd4,
    WAIT     = 3'd5
  } lcd_state_e;

  // Default timing in clk cycles at 50 MHz.
  localparam int INIT_WAIT_DEF = 1000000;  // 20 ms power-on
  localparam int CMD_WAIT_DEF  = 4500;     // 90 us per normal command
  localparam int CLR_WAIT_DEF  = 82000;    // 1.64 ms for clear/home
  localparam int SETUP_CYC_DEF = 2;
  localparam int EN_WIDTH_DEF  = 13;

  localparam int NUM_INIT = 6;

  // Power-on command table: function set (x2), display off, clear,
  // entry mode, display on.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h30;
      3'd1:    return 8'h38;
      3'd2:    return 8'h08;
      3'd3:    return 8'h01;
      3'd4:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction

  // Clear (0x01) and home (0x02) commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02);
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter. On a tie the port not granted last wins;
// the last-grant register only moves when the grant is actually taken.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;  // 1: port 1 was granted last

  // Grant selection: single requester wins outright, a tie alternates.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  // Remember who was served; reset value makes port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= 1'b1;
    else if (upd_i) last_q <= gnt_o[1];
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780-style write-only LCD bus between two requesters.
// After power-on it plays the six-command init table, then serves
// requests round-robin, one SETUP/PULSE/WAIT transaction at a time.
// Assumes INIT_WAIT >= 2, SETUP_CYC >= 1, EN_WIDTH >= 1 and both
// transaction lengths longer than SETUP_CYC + EN_WIDTH.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int INIT_WAIT = INIT_WAIT_DEF,
  parameter int CMD_WAIT  = CMD_WAIT_DEF,
  parameter int CLR_WAIT  = CLR_WAIT_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int EN_WIDTH  = EN_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  // PWR_WAIT plus the one-cycle INIT_CMD together span INIT_WAIT cycles.
  localparam logic [31:0] PWR_LAST   = 32'(INIT_WAIT - 2);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] PULSE_LAST = 32'(SETUP_CYC + EN_WIDTH - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT - 1);

  lcd_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        clr_q, clr_d;
  logic [1:0]  ack_q, ack_d;

  logic [1:0]  gnt;
  logic        arb_upd;
  logic        load_init;
  logic        load_req;

  lcd_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1, req0}),
    .upd_i (arb_upd),
    .gnt_o (gnt)
  );

  // Next-state logic. Every transaction start (init or user) goes through
  // one common load path so timing is identical for both.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    clr_d       = clr_q;
    ack_d       = 2'b00;
    arb_upd     = 1'b0;
    load_init   = 1'b0;
    load_req    = 1'b0;

    case (state_q)
      PWR_WAIT: if (cnt_q == PWR_LAST) state_d = INIT_CMD;
      INIT_CMD: load_init = 1'b1;
      IDLE: begin
        cnt_d    = cnt_q;
        load_req = |gnt;
      end
      SETUP:    if (cnt_q == SETUP_LAST) state_d = PULSE;
      PULSE:    if (cnt_q == PULSE_LAST) state_d = WAIT;
      WAIT: begin
        if (cnt_q == (clr_q ? CLR_LAST : CMD_LAST)) begin
          if (!init_done_q) begin
            if (idx_q == 3'(NUM_INIT - 1)) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
              cnt_d       = 32'd0;
            end else begin
              idx_d     = idx_q + 3'd1;
              load_init = 1'b1;
            end
          end else if (|gnt) begin
            // A waiting request chains straight into the next SETUP.
            load_req = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 32'd0;
          end
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = 32'd0;
      end
    endcase

    if (load_init) begin
      state_d = SETUP;
      cnt_d   = 32'd0;
      rs_d    = 1'b0;
      data_d  = init_cmd(idx_d);
      clr_d   = is_long_cmd(rs_d, data_d);
    end

    if (load_req) begin
      state_d = SETUP;
      cnt_d   = 32'd0;
      rs_d    = gnt[1] ? rs1 : rs0;
      data_d  = gnt[1] ? data1 : data0;
      clr_d   = is_long_cmd(rs_d, data_d);
      ack_d   = gnt;
      arb_upd = 1'b1;
    end
  end

  // State, counter and latched bus values; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= 32'd0;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      clr_q       <= 1'b0;
      ack_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      clr_q       <= clr_d;
      ack_q       <= ack_d;
    end
  end

  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign busy      = (state_q != IDLE);
  assign init_done = init_done_q;
  assign LCD_EN    = (state_q == PULSE);
  assign LCD_RW    = 1'b0;
  assign LCD_RS    = rs_q;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios plus random two-port
// traffic, checked against a transaction-level model of the bus
// (grant edge, EN window, busy window computed from the timing rules).
module tb_lcd_bus_arbiter;

  localparam int P_INIT  = 20;
  localparam int P_CMD   = 30;
  localparam int P_CLR   = 60;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;

  logic       clk, rst_n;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy, init_done;
  logic       LCD_EN, LCD_RW, LCD_RS;
  logic [7:0] LCD_DATA;

  lcd_bus_arbiter #(
    .INIT_WAIT (P_INIT),
    .CMD_WAIT  (P_CMD),
    .CLR_WAIT  (P_CLR),
    .SETUP_CYC (P_SETUP),
    .EN_WIDTH  (P_EN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .rs0       (rs0),
    .rs1       (rs1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .init_done (init_done),
    .LCD_EN    (LCD_EN),
    .LCD_RW    (LCD_RW),
    .LCD_RS    (LCD_RS),
    .LCD_DATA  (LCD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int edge_n; logic rs; logic [7:0] data;} en_ev_t;
  typedef struct {int edge_n; int port;} ack_ev_t;

  en_ev_t  exp_en[$];
  ack_ev_t exp_ack[$];
  logic [7:0] init_seq [6] = '{8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  int   checks, failures;
  int   n, m_free, m_last, init_end;
  logic exp_busy;
  logic en_prev;
  int   rise_n;
  logic ack_flag;
  int   ack_port, ack_edge;
  logic id_seen;
  int   id_edge;
  logic auto_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tx_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD;
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 3))
      0:       return 8'h01;
      1:       return 8'h02;
      default: return 8'($urandom);
    endcase
  endfunction

  // Rebuild the expected power-on schedule from the command table.
  task automatic model_reset();
    int start;
    n = 0; m_last = 1; m_free = 0; exp_busy = 1'b1;
    en_prev = 1'b0; rise_n = 0; id_seen = 1'b0; id_edge = -1;
    exp_en.delete(); exp_ack.delete();
    start = P_INIT;
    for (int k = 0; k < 6; k++) begin
      exp_en.push_back('{start + P_SETUP, 1'b0, init_seq[k]});
      start += tx_len(1'b0, init_seq[k]);
    end
    init_end = start;
  endtask

  // One clock edge of the bus model: a request seen on an edge where the
  // bus is free (and init has finished before it) is granted on that edge.
  task automatic model_edge();
    int   p;
    logic g;
    n++;
    g = 1'b0;
    if (n > init_end && n >= m_free && (req0 || req1)) begin
      p = (req0 && req1) ? ((m_last == 1) ? 0 : 1) : (req1 ? 1 : 0);
      exp_ack.push_back('{n, p});
      if (p == 1) begin
        exp_en.push_back('{n + P_SETUP, rs1, data1});
        m_free = n + tx_len(rs1, data1);
      end else begin
        exp_en.push_back('{n + P_SETUP, rs0, data0});
        m_free = n + tx_len(rs0, data0);
      end
      m_last = p;
      g = 1'b1;
    end
    exp_busy = !(n >= init_end && n >= m_free && !g);
  endtask

  task automatic monitor();
    logic [1:0] ea;
    chk("lcd_rw", LCD_RW, 0);
    chk("busy", busy, exp_busy);
    chk("init_done", init_done, (n >= init_end));
    if (init_done && !id_seen) begin id_seen = 1'b1; id_edge = n; end
    ea = 2'b00;
    if (exp_ack.size() > 0 && exp_ack[0].edge_n == n) begin
      ea = (exp_ack[0].port == 1) ? 2'b10 : 2'b01;
      exp_ack.delete(0);
    end
    chk("ack", {ack1, ack0}, ea);
    if (ack0 || ack1) begin
      ack_flag = 1'b1; ack_port = ack1 ? 1 : 0; ack_edge = n;
    end
    if (exp_en.size() > 0 && exp_en[0].edge_n < n) begin
      chk("en_missing", n, exp_en[0].edge_n);
      exp_en.delete(0);
    end
    if (LCD_EN && !en_prev) begin
      chk("en_expected", exp_en.size() != 0, 1);
      if (exp_en.size() != 0) begin
        chk("en_edge", n, exp_en[0].edge_n);
        chk("en_rs", LCD_RS, exp_en[0].rs);
        chk("en_data", LCD_DATA, exp_en[0].data);
        exp_en.delete(0);
      end
      rise_n = n;
    end
    if (!LCD_EN && en_prev) chk("en_width", n - rise_n, P_EN);
    en_prev = LCD_EN;
  endtask

  // Advance one clock: model on the rising edge, checks on the falling edge,
  // then requesters drop a request once it has been acknowledged.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    if (rst_n) monitor();
    if (auto_drop) begin
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_ack(input string tag, input int bound);
    ack_flag = 1'b0;
    for (int i = 0; i < bound && !ack_flag; i++) step();
    chk(tag, ack_flag, 1);
  endtask

  int ports [4];
  int edges [4];
  int g1, gstart;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; auto_drop = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    ack_flag = 1'b0; ack_port = 0; ack_edge = 0;
    model_reset();
    step(); step();

    // Reset state.
    chk("rst_en", LCD_EN, 0);
    chk("rst_rw", LCD_RW, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_data", LCD_DATA, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);

    // Release with a data write already pending: held off until init ends.
    rst_n = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h35;
    wait_ack("early_ack_seen", 400);
    chk("early_ack_port", ack_port, 0);
    chk("early_ack_edge", ack_edge, 231);
    chk("init_done_edge", id_edge, 230);
    gstart = ack_edge;
    wait_idle("tx_idle");
    chk("tx_busy_len", n - gstart, P_CMD);
    chk("hold_rs", LCD_RS, 1);
    chk("hold_data", LCD_DATA, 8'h35);

    // Both ports held high: alternate grants, back-to-back.
    step();
    auto_drop = 1'b0;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr_ack_seen", 100);
      ports[k] = ack_port;
      edges[k] = ack_edge;
    end
    req0 = 1'b0; req1 = 1'b0; auto_drop = 1'b1;
    chk("rr_first", ports[0], 1);
    for (int k = 1; k < 4; k++) begin
      chk("rr_alt", ports[k] != ports[k-1], 1);
      chk("rr_gap", edges[k] - edges[k-1], P_CMD);
    end
    wait_idle("rr_idle");

    // Clear command on port 1; port 0 arrives mid-transaction.
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
    wait_ack("clr_ack1_seen", 20);
    chk("clr_ack1_port", ack_port, 1);
    g1 = ack_edge;
    for (int i = 0; i < 10; i++) step();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
    wait_ack("clr_ack0_seen", 100);
    chk("clr_ack0_port", ack_port, 0);
    chk("clr_ack0_gap", ack_edge - g1, P_CLR);
    wait_idle("clr_idle");

    // Random two-port traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (!req0 && $urandom_range(0, 5) == 0) begin
        req0 = 1'b1; rs0 = 1'($urandom_range(0, 1)); data0 = pick();
      end
      if (!req1 && $urandom_range(0, 5) == 0) begin
        req1 = 1'b1; rs1 = 1'($urandom_range(0, 1)); data1 = pick();
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("rand_idle");

    // Reset in the middle of an EN pulse.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA5;
    for (int i = 0; i < 100; i++) begin
      step();
      if (LCD_EN) break;
    end
    chk("pulse_reached", LCD_EN, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_en", LCD_EN, 0);
    chk("rst2_init_done", init_done, 0);
    chk("rst2_busy", busy, 1);
    chk("rst2_data", LCD_DATA, 0);
    chk("rst2_rs", LCD_RS, 0);
    model_reset();
    req0 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    req0 = 1'b1; rs0 = 1'b0; data0 = 8'h02;
    wait_ack("re_ack_seen", 400);
    chk("re_ack_port", ack_port, 0);
    chk("re_ack_edge", ack_edge, 231);
    chk("re_init_done_edge", id_edge, 230);
    wait_idle("re_idle");
    chk("en_queue_drained", exp_en.size(), 0);
    chk("ack_queue_drained", exp_ack.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
